sub2_link_master: RTL and testbench
===================================

Name: sub2_link_master

Overview:
- Drives the input side of sub2 and collects its outputs.
- Receives a fixed-length command frame on a byte stream and unpacks it into sub2's scalar, vector, packed-array, unpacked-array and parameter inputs, pulsing an apply strobe.
- After a programmable settle delay it samples sub2's outputs, packs them into a fixed-length response frame and transmits it on an outbound byte stream.
- Sits between the host byte link and sub2.

Parameters:
RSP_DELAY, 2, cycles from the apply cycle to the response sample; legal range 1..15.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
s_valid  input  1  command byte valid
s_ready  output  1  command byte accepted when s_valid&&s_ready
s_data  input  8  command byte
s_last  input  1  final byte of command frame
m_valid  output  1  response byte valid
m_ready  input  1  response byte consumed when m_valid&&m_ready
m_data  output  8  response byte
m_last  output  1  final response byte
o_sig_e  output  1  to sub2 i_sig_e
o_sig_f  output  [1:0]  to sub2 i_sig_f
o_sig_g  output  [0:2][7:0]  to sub2 i_sig_g (packed)
o_sig_h  output  [7:0] x [0:2]  to sub2 i_sig_h (unpacked)
o_param_a  output  [4:0][7:0]  to sub2 param_a
o_param_b  output  [2:0][7:0]  to sub2 param_b
o_apply  output  1  one-cycle pulse: new values valid this cycle
i_sig_i  input  1  from sub2 o_sig_i
i_sig_j  input  [1:0]  from sub2 o_sig_j
i_sig_k  input  [0:2][7:0]  from sub2 o_sig_k
i_sig_l  input  [7:0] x [0:2]  from sub2 o_sig_l (unpacked)
o_frame_err  output  1  one-cycle pulse on malformed command frame

Behaviour:
- Command frame, 15 bytes, in order:
  - B0: bit0=e, bits2:1=f, bits7:3 ignored.
  - B1-B3: g[0],g[1],g[2].
  - B4-B6: h[0],h[1],h[2].
  - B7-B11: param_a[0]..param_a[4].
  - B12-B14: param_b[0]..param_b[2].
  - Element index is numeric, independent of range direction.
- Response frame, 7 bytes, in order:
  - R0: {5'b0, j[1:0], i}.
  - R1-R3: k[0..2].
  - R4-R6: l[0..2].
- Reset: state RX, byte index 0, all o_sig_*/o_param_* = 0, o_apply=0, o_frame_err=0, m_valid=0, m_last=0, m_data=0.
- FSM states: RX, DRAIN, APPLY, WAIT, TX.
- RX:
  - s_ready=1.
  - Each accepted byte is written to staging regs; the index increments.
  - s_last on index<14: o_frame_err pulse next cycle, index→0, outputs unchanged, stay RX.
  - Index 14 with s_last=1 → APPLY.
  - Index 14 with s_last=0 → DRAIN.
- DRAIN:
  - s_ready=1; bytes are discarded.
  - On accepted s_last: o_frame_err pulse, index→0, → RX. Outputs unchanged.
- APPLY:
  - Staging regs are copied to outputs on the edge entering APPLY, so new values and o_apply=1 coincide in this one cycle.
  - s_ready=0.
  - Next state WAIT with counter=RSP_DELAY-1.
- WAIT:
  - Decrement the counter.
  - When the counter is 0, i_sig_* are sampled into the response regs on that edge, then → TX.
  - Sample instant is exactly RSP_DELAY cycles after the o_apply cycle.
- TX:
  - m_valid=1; emit R0..R6; m_last=1 on R6 only.
  - m_data/m_last are held stable while m_valid&&!m_ready; no bubbles are required between bytes.
  - After R6 is accepted: m_valid=0 next cycle, → RX.
- s_ready=0 in APPLY/WAIT/TX. Command bytes presented then are not consumed.
- Outputs to sub2 hold their values until the next good frame; bad frames never disturb them.
- A reset asserted mid-frame or mid-response returns to reset values on that edge. A partial response is abandoned; m_valid drops without m_last.
- Throughput: minimum turnaround = 15 + 1 + RSP_DELAY + 7 cycles.

Test Plan:
- Good frame B0=0x05, g=11,22,33, h=44,55,66, a=A0..A4, b=B0..B2, no stalls → o_apply single pulse, o_sig_e=1, o_sig_f=2'b10, o_sig_g[1]=0x22, o_sig_h[2]=0x66, o_param_a[4]=0xA4, o_param_b[0]=0xB0.
- Loopback model with sub2 outputs i=1, j=2'b01, k=77,88,99, l=1A,2B,3C → response 03,77,88,99,1A,2B,3C, m_last on 0x3C only, sampled exactly RSP_DELAY=2 cycles after o_apply.
- Random m_ready throttling (~50% low) → m_data held stable during stalls, 7 bytes in order, no duplicates.
- s_last on byte 5 → o_frame_err pulse, outputs keep previous frame values, no o_apply; next good frame is accepted normally.
- 17-byte frame with s_last on byte 16 → DRAIN, o_frame_err once, no o_apply, s_ready stays 1 until s_last.
- rst asserted during TX at R3 → next cycle m_valid=0, all outputs 0, then a good frame works from index 0.

Source files
------------

// File: rtl/sub2_link_master.sv
// Byte-link front end for sub2: unpacks a 15-byte command frame into sub2 inputs,
// then returns sub2 outputs as a 7-byte response after a settle delay.
module sub2_link_master #(
  parameter int unsigned RSP_DELAY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic             o_sig_e,
  output logic [1:0]       o_sig_f,
  output logic [0:2][7:0]  o_sig_g,
  output logic [7:0]       o_sig_h [0:2],
  output logic [4:0][7:0]  o_param_a,
  output logic [2:0][7:0]  o_param_b,
  output logic             o_apply,
  input  logic             i_sig_i,
  input  logic [1:0]       i_sig_j,
  input  logic [0:2][7:0]  i_sig_k,
  input  logic [7:0]       i_sig_l [0:2],
  output logic             o_frame_err
);

  localparam int unsigned IDX_W   = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TX_W    = 3;
  localparam int unsigned CMD_LEN = 15;
  localparam int unsigned RSP_LEN = 7;

  typedef enum logic [2:0] {S_RX, S_DRAIN, S_APPLY, S_WAIT, S_TX} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rx_idx;
  logic [2:0]       stg_ef;
  logic [7:0]       stg [1:13];
  logic [CNT_W-1:0] cnt;
  logic [TX_W-1:0]  tx_idx;
  logic [7:0]       rsp [0:6];

  logic cmd_acc, rsp_acc, last_idx, last_tx;

  assign cmd_acc  = s_valid && s_ready;
  assign rsp_acc  = m_valid && m_ready;
  assign last_idx = (rx_idx == IDX_W'(CMD_LEN - 1));
  assign last_tx  = (tx_idx == TX_W'(RSP_LEN - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_RX;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_RX:    if (cmd_acc && last_idx) state_nxt = s_last ? S_APPLY : S_DRAIN;
      S_DRAIN: if (cmd_acc && s_last) state_nxt = S_RX;
      S_APPLY: state_nxt = S_WAIT;
      S_WAIT:  if (cnt == '0) state_nxt = S_TX;
      S_TX:    if (rsp_acc && last_tx) state_nxt = S_RX;
      default: state_nxt = S_RX;
    endcase
  end

  // Link handshake outputs decoded from state
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_data  = 8'h00;
    case (state)
      S_RX, S_DRAIN: s_ready = 1'b1;
      S_TX: begin
        m_valid = 1'b1;
        m_last  = last_tx;
        m_data  = rsp[tx_idx];
      end
      default: ;
    endcase
  end

  // Staging, sub2-side outputs, settle counter and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_idx      <= '0;
      stg_ef      <= '0;
      cnt         <= '0;
      tx_idx      <= '0;
      o_apply     <= 1'b0;
      o_frame_err <= 1'b0;
      o_sig_e     <= 1'b0;
      o_sig_f     <= '0;
      o_sig_g     <= '0;
      o_param_a   <= '0;
      o_param_b   <= '0;
      for (int i = 1; i <= 13; i++) stg[i] <= '0;
      for (int i = 0; i < 3; i++) o_sig_h[i] <= '0;
      for (int i = 0; i < 7; i++) rsp[i] <= '0;
    end else begin
      o_apply     <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        S_RX: begin
          if (cmd_acc) begin
            if (last_idx) begin
              rx_idx <= '0;
              // Final byte goes straight to param_b[2]; everything lands together with o_apply
              if (s_last) begin
                o_apply      <= 1'b1;
                o_sig_e      <= stg_ef[0];
                o_sig_f      <= stg_ef[2:1];
                for (int i = 0; i < 3; i++) o_sig_g[i]   <= stg[1 + i];
                for (int i = 0; i < 3; i++) o_sig_h[i]   <= stg[4 + i];
                for (int i = 0; i < 5; i++) o_param_a[i] <= stg[7 + i];
                o_param_b[0] <= stg[12];
                o_param_b[1] <= stg[13];
                o_param_b[2] <= s_data;
              end
            end else if (s_last) begin
              o_frame_err <= 1'b1;
              rx_idx      <= '0;
            end else begin
              if (rx_idx == '0) stg_ef <= s_data[2:0];
              else              stg[rx_idx] <= s_data;
              rx_idx <= rx_idx + IDX_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (cmd_acc && s_last) o_frame_err <= 1'b1;
        end
        S_APPLY: cnt <= CNT_W'(RSP_DELAY - 1);
        S_WAIT: begin
          if (cnt == '0) begin
            rsp[0] <= {5'b0, i_sig_j, i_sig_i};
            for (int i = 0; i < 3; i++) rsp[1 + i] <= i_sig_k[i];
            for (int i = 0; i < 3; i++) rsp[4 + i] <= i_sig_l[i];
            tx_idx <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_TX: begin
          if (rsp_acc) tx_idx <= last_tx ? '0 : tx_idx + TX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub2_link_master.sv
// Directed bench for sub2_link_master: frame unpacking, response timing/order,
// malformed frames and mid-response reset.
module tb_sub2_link_master;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid, s_ready, s_last;
  logic [7:0]       s_data;
  logic             m_valid, m_ready, m_last;
  logic [7:0]       m_data;
  logic             o_sig_e;
  logic [1:0]       o_sig_f;
  logic [0:2][7:0]  o_sig_g;
  logic [7:0]       o_sig_h [0:2];
  logic [4:0][7:0]  o_param_a;
  logic [2:0][7:0]  o_param_b;
  logic             o_apply;
  logic             i_sig_i;
  logic [1:0]       i_sig_j;
  logic [0:2][7:0]  i_sig_k;
  logic [7:0]       i_sig_l [0:2];
  logic             o_frame_err;

  int checks = 0;
  int failures = 0;
  int apply_cnt = 0;
  int err_cnt = 0;
  int a0, e0;

  logic [7:0] cmd [0:16];
  logic [7:0] exp_rsp [0:6];
  logic [7:0] got_d [0:6];
  logic       got_l [0:6];

  always #5 clk = ~clk;

  sub2_link_master #(.RSP_DELAY(2)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .o_sig_e(o_sig_e), .o_sig_f(o_sig_f), .o_sig_g(o_sig_g), .o_sig_h(o_sig_h),
    .o_param_a(o_param_a), .o_param_b(o_param_b), .o_apply(o_apply),
    .i_sig_i(i_sig_i), .i_sig_j(i_sig_j), .i_sig_k(i_sig_k), .i_sig_l(i_sig_l),
    .o_frame_err(o_frame_err)
  );

  // Pulse counters for apply / frame-error events
  always @(posedge clk) begin
    if (o_apply === 1'b1)     apply_cnt <= apply_cnt + 1;
    if (o_frame_err === 1'b1) err_cnt   <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input int n);
    for (int k = 0; k < n; k++) begin
      s_valid = 1'b1;
      s_data  = cmd[k];
      s_last  = (k == n - 1);
      check("s_ready_rx", 32'(s_ready), 32'd1);
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
  endtask

  task automatic recv(input int n, input bit stall);
    int         got = 0;
    int         budget = 0;
    logic [7:0] prev_d = 8'h00;
    logic       prev_l = 1'b0;
    bit         prev_stall = 1'b0;
    while (got < n && budget < 200) begin
      if (prev_stall) begin
        check("hold_data", 32'(m_data), 32'(prev_d));
        check("hold_last", 32'(m_last), 32'(prev_l));
      end
      m_ready    = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      prev_stall = m_valid && !m_ready;
      prev_d     = m_data;
      prev_l     = m_last;
      if (m_valid && m_ready) begin
        got_d[got] = m_data;
        got_l[got] = m_last;
        got++;
      end
      step();
      budget++;
    end
    m_ready = 1'b0;
    check("rsp_count", 32'(got), 32'(n));
  endtask

  task automatic check_rsp(input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("rsp_byte%0d", i), 32'(got_d[i]), 32'(exp_rsp[i]));
      check($sformatf("rsp_last%0d", i), 32'(got_l[i]), 32'(i == 6));
    end
  endtask

  task automatic set_wrong_loopback();
    i_sig_i = 1'b0; i_sig_j = 2'b10;
    for (int i = 0; i < 3; i++) begin i_sig_k[i] = 8'hEE; i_sig_l[i] = 8'hEE; end
  endtask

  task automatic frame1();
    cmd[0] = 8'h05;
    for (int k = 1; k <= 6; k++) cmd[k] = 8'(8'h11 * k);
    for (int i = 0; i < 5; i++) cmd[7 + i] = 8'(8'hA0 + i);
    for (int i = 0; i < 3; i++) cmd[12 + i] = 8'(8'hB0 + i);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; m_ready = 1'b0;
    set_wrong_loopback();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_apply", 32'(o_apply), 32'd0);
    check("rst_err", 32'(o_frame_err), 32'd0);
    check("rst_param_a", 32'(o_param_a), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);

    // Frame 1: unpack and sample-instant check
    frame1();
    send(15);
    check("f1_apply", 32'(o_apply), 32'd1);
    check("f1_e", 32'(o_sig_e), 32'd1);
    check("f1_f", 32'(o_sig_f), 32'h2);
    check("f1_g0", 32'(o_sig_g[0]), 32'h11);
    check("f1_g1", 32'(o_sig_g[1]), 32'h22);
    check("f1_h0", 32'(o_sig_h[0]), 32'h44);
    check("f1_h2", 32'(o_sig_h[2]), 32'h66);
    check("f1_a0", 32'(o_param_a[0]), 32'hA0);
    check("f1_a4", 32'(o_param_a[4]), 32'hA4);
    check("f1_b0", 32'(o_param_b[0]), 32'hB0);
    check("f1_b2", 32'(o_param_b[2]), 32'hB2);
    check("f1_s_ready_apply", 32'(s_ready), 32'd0);
    step();
    check("f1_apply_pulse", 32'(o_apply), 32'd0);
    step();
    // Correct values present only in the cycle RSP_DELAY after the apply cycle
    i_sig_i = 1'b1; i_sig_j = 2'b01;
    i_sig_k[0] = 8'h77; i_sig_k[1] = 8'h88; i_sig_k[2] = 8'h99;
    i_sig_l[0] = 8'h1A; i_sig_l[1] = 8'h2B; i_sig_l[2] = 8'h3C;
    step();
    set_wrong_loopback();
    exp_rsp[0] = 8'h03; exp_rsp[1] = 8'h77; exp_rsp[2] = 8'h88; exp_rsp[3] = 8'h99;
    exp_rsp[4] = 8'h1A; exp_rsp[5] = 8'h2B; exp_rsp[6] = 8'h3C;
    recv(7, 1'b0);
    check_rsp(7);
    check("f1_m_valid_drop", 32'(m_valid), 32'd0);
    check("f1_s_ready_back", 32'(s_ready), 32'd1);

    // Constant loopback from here on
    i_sig_i = 1'b0; i_sig_j = 2'b11;
    i_sig_k[0] = 8'h01; i_sig_k[1] = 8'h02; i_sig_k[2] = 8'h03;
    i_sig_l[0] = 8'hF0; i_sig_l[1] = 8'hE1; i_sig_l[2] = 8'hD2;
    exp_rsp[0] = 8'h06; exp_rsp[1] = 8'h01; exp_rsp[2] = 8'h02; exp_rsp[3] = 8'h03;
    exp_rsp[4] = 8'hF0; exp_rsp[5] = 8'hE1; exp_rsp[6] = 8'hD2;

    // Frame 2 with throttled response
    cmd[0] = 8'h02;
    for (int k = 1; k <= 6; k++) cmd[k] = 8'(k * 16);
    for (int i = 0; i < 5; i++) cmd[7 + i] = 8'(8'hC0 + i);
    for (int i = 0; i < 3; i++) cmd[12 + i] = 8'(8'hD0 + i);
    send(15);
    check("f2_apply", 32'(o_apply), 32'd1);
    check("f2_e", 32'(o_sig_e), 32'd0);
    check("f2_f", 32'(o_sig_f), 32'h1);
    check("f2_g2", 32'(o_sig_g[2]), 32'h30);
    check("f2_h1", 32'(o_sig_h[1]), 32'h50);
    check("f2_a0", 32'(o_param_a[0]), 32'hC0);
    check("f2_b1", 32'(o_param_b[1]), 32'hD1);
    recv(7, 1'b1);
    check_rsp(7);

    // Short frame: s_last on byte 5
    a0 = apply_cnt; e0 = err_cnt;
    for (int k = 0; k < 6; k++) cmd[k] = 8'hFF;
    send(6);
    check("short_err", 32'(o_frame_err), 32'd1);
    step();
    check("short_err_pulse", 32'(o_frame_err), 32'd0);
    check("short_err_cnt", 32'(err_cnt), 32'(e0 + 1));
    check("short_no_apply", 32'(apply_cnt), 32'(a0));
    check("short_keep_a0", 32'(o_param_a[0]), 32'hC0);
    check("short_keep_g2", 32'(o_sig_g[2]), 32'h30);
    check("short_keep_f", 32'(o_sig_f), 32'h1);

    // Frame 3 after the bad one; ignored upper bits of byte 0
    cmd[0] = 8'hFB;
    for (int k = 1; k < 15; k++) cmd[k] = 8'(8'h80 + k);
    send(15);
    check("f3_apply", 32'(o_apply), 32'd1);
    check("f3_e", 32'(o_sig_e), 32'd1);
    check("f3_f", 32'(o_sig_f), 32'h1);
    check("f3_h1", 32'(o_sig_h[1]), 32'h85);
    check("f3_a4", 32'(o_param_a[4]), 32'h8B);
    check("f3_b2", 32'(o_param_b[2]), 32'h8E);
    recv(7, 1'b0);
    check_rsp(7);

    // Long frame: 17 bytes, s_last on byte 16
    a0 = apply_cnt; e0 = err_cnt;
    for (int k = 0; k < 17; k++) cmd[k] = 8'h5A;
    send(17);
    check("long_err", 32'(o_frame_err), 32'd1);
    step();
    check("long_err_cnt", 32'(err_cnt), 32'(e0 + 1));
    check("long_no_apply", 32'(apply_cnt), 32'(a0));
    check("long_keep_b2", 32'(o_param_b[2]), 32'h8E);
    check("long_keep_g0", 32'(o_sig_g[0]), 32'h81);

    // Reset while presenting R3
    frame1();
    send(15);
    recv(3, 1'b0);
    check("pre_rst_valid", 32'(m_valid), 32'd1);
    check("pre_rst_r3", 32'(m_data), 32'h03);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_last", 32'(m_last), 32'd0);
    check("mid_rst_data", 32'(m_data), 32'd0);
    check("mid_rst_e", 32'(o_sig_e), 32'd0);
    check("mid_rst_h0", 32'(o_sig_h[0]), 32'd0);
    check("mid_rst_a", 32'(o_param_a), 32'd0);
    check("mid_rst_b", 32'(o_param_b), 32'd0);
    check("mid_rst_s_ready", 32'(s_ready), 32'd1);
    send(15);
    check("post_rst_apply", 32'(o_apply), 32'd1);
    check("post_rst_g1", 32'(o_sig_g[1]), 32'h22);
    check("post_rst_b0", 32'(o_param_b[0]), 32'hB0);
    recv(7, 1'b1);
    check_rsp(7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
